// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: rising-edge detector on N_CH lines with per-channel
// pending/overflow flags, served round-robin over a single valid/ready port.
module edge_event_arbiter #(
  parameter int N_CH  = 4,
  parameter int IDX_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_CH-1:0]  din,
  input  logic [N_CH-1:0]  en,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [IDX_W-1:0] evt_ch,
  output logic [N_CH-1:0]  pending,
  output logic [N_CH-1:0]  overflow,
  input  logic             clr_ovf
);

  typedef enum logic {IDLE = 1'b0, OFFER = 1'b1} state_t;

  state_t              state;
  logic [N_CH-1:0]     din_q;
  logic [N_CH-1:0]     rise;
  logic [N_CH-1:0]     acc;
  logic [N_CH-1:0]     pending_nxt;
  logic [N_CH-1:0]     overflow_nxt;
  logic [2*N_CH-1:0]   dbl;
  logic [N_CH-1:0]     rot;
  logic                found;
  logic [IDX_W:0]      sum;
  logic [IDX_W-1:0]    pick;
  logic [IDX_W-1:0]    nxt_ptr;
  logic [IDX_W-1:0]    rr_ptr;

  assign rise = din & ~din_q & en;

  // Decode which channel's event is being accepted this cycle.
  always_comb begin
    acc = '0;
    for (int i = 0; i < N_CH; i++) begin
      acc[i] = evt_valid & evt_ready & (evt_ch == IDX_W'(i));
    end
  end

  // Next pending/overflow: a fresh edge wins over acceptance; an edge on an
  // unaccepted pending channel coalesces and marks overflow (set beats clear).
  always_comb begin
    pending_nxt  = pending;
    overflow_nxt = overflow;
    for (int i = 0; i < N_CH; i++) begin
      if (rise[i] & pending[i] & ~acc[i]) begin
        overflow_nxt[i] = 1'b1;
      end else if (clr_ovf) begin
        overflow_nxt[i] = 1'b0;
      end
      if (rise[i]) begin
        pending_nxt[i] = 1'b1;
      end else if (acc[i]) begin
        pending_nxt[i] = 1'b0;
      end
    end
  end

  // Round-robin search: rotate pending so rr_ptr sits at bit 0, take the
  // lowest set bit, then map the offset back to a channel index mod N_CH.
  always_comb begin
    dbl   = {pending, pending};
    rot   = N_CH'(dbl >> rr_ptr);
    found = 1'b0;
    sum   = '0;
    for (int k = N_CH - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        sum   = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      end
    end
    if (sum >= (IDX_W+1)'(N_CH)) begin
      sum = sum - (IDX_W+1)'(N_CH);
    end
    pick    = sum[IDX_W-1:0];
    nxt_ptr = (evt_ch == IDX_W'(N_CH - 1)) ? '0 : evt_ch + IDX_W'(1);
  end

  // Edge history and per-channel event flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_q    <= '0;
      pending  <= '0;
      overflow <= '0;
    end else begin
      din_q    <= din;
      pending  <= pending_nxt;
      overflow <= overflow_nxt;
    end
  end

  // Offer FSM: IDLE picks a pending channel, OFFER holds it until accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      evt_valid <= 1'b0;
      evt_ch    <= '0;
      rr_ptr    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (found) begin
            evt_ch    <= pick;
            evt_valid <= 1'b1;
            state     <= OFFER;
          end
        end
        OFFER: begin
          if (evt_ready) begin
            evt_valid <= 1'b0;
            rr_ptr    <= nxt_ptr;
            state     <= IDLE;
          end
        end
        default: begin
          evt_valid <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
